axi_read_arbiter: RTL and testbench

Two-requester arbiter sharing the core's single AXI4-lite read channel between the instruction-fetch path and the data-load path. It accepts one request at a time, drives the AR/R handshakes with the correct protection flags, and routes the returned word and status back to the requester that won. It sits between the fetch/load sequencing logic and the external AXI4-lite read ports. It also raises a sticky trap on any read error.

---
 rtl/axi_read_arbiter_if.sv | 21 ++
 rtl/axi_read_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_arbiter_if.sv
// AXI4-lite read channel (AR + R) shared between the arbiter and the external slave.
interface axi_read_arbiter_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddress;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output arvalid, araddress, arprot, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddress, arprot, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4-lite read channel between instruction fetch and data load,
// one transaction at a time, with round-robin tie breaking and a sticky error trap.
module axi_read_arbiter #(
    parameter logic [2:0] INSTR_PROT = 3'b101,
    parameter logic [2:0] DATA_PROT  = 3'b000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    input  logic [31:0]                i_addr,
    output logic                       i_ready,
    output logic                       i_rvalid,
    output logic [31:0]                i_rdata,
    output logic                       i_err,
    input  logic                       d_valid,
    input  logic [31:0]                d_addr,
    output logic                       d_ready,
    output logic                       d_rvalid,
    output logic [31:0]                d_rdata,
    output logic                       d_err,
    axi_read_arbiter_if.master         axi,
    output logic                       busy,
    output logic                       trap,
    output logic [1:0]                 trap_code
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        owner_q, owner_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arprot_q, arprot_d;
    logic        rready_q, rready_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        i_rvalid_q, i_rvalid_d;
    logic        d_rvalid_q, d_rvalid_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_err_q, i_err_d;
    logic        d_err_q, d_err_d;
    logic        trap_q, trap_d;
    logic        grant;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arprot_d     = arprot_q;
        rready_d     = rready_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        i_rvalid_d   = 1'b0;
        d_rvalid_d   = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_err_d      = i_err_q;
        d_err_d      = d_err_q;
        trap_d       = trap_q;
        // On a tie the port that did not win last time gets the grant.
        grant        = (i_valid && d_valid) ? ~last_grant_q : d_valid;

        case (state_q)
            IDLE: begin
                if (i_valid || d_valid) begin
                    owner_d      = grant;
                    last_grant_d = grant;
                    araddr_d     = (grant == PORT_D) ? d_addr : i_addr;
                    arprot_d     = (grant == PORT_D) ? DATA_PROT : INSTR_PROT;
                    arvalid_d    = 1'b1;
                    i_ready_d    = (grant == PORT_I);
                    d_ready_d    = (grant == PORT_D);
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (axi.rvalid) begin
                    rready_d = 1'b0;
                    if (owner_q == PORT_D) begin
                        d_rdata_d  = axi.rdata;
                        d_err_d    = axi.rresp[1];
                        d_rvalid_d = 1'b1;
                    end else begin
                        i_rdata_d  = axi.rdata;
                        i_err_d    = axi.rresp[1];
                        i_rvalid_d = 1'b1;
                    end
                    if (axi.rresp[1]) begin
                        trap_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset favours the instruction port on the first tie by recording data as last winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_D;
            owner_q      <= PORT_I;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arprot_q     <= '0;
            rready_q     <= 1'b0;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arprot_q     <= arprot_d;
            rready_q     <= rready_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
            trap_q       <= trap_d;
        end
    end

    assign axi.arvalid   = arvalid_q;
    assign axi.araddress = araddr_q;
    assign axi.arprot    = arprot_q;
    assign axi.rready    = rready_q;
    assign i_ready       = i_ready_q;
    assign d_ready       = d_ready_q;
    assign i_rvalid      = i_rvalid_q;
    assign d_rvalid      = d_rvalid_q;
    assign i_rdata       = i_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign i_err         = i_err_q;
    assign d_err         = d_err_q;
    assign busy          = (state_q != IDLE);
    assign trap          = trap_q;
    assign trap_code     = 2'b00;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed self-checking bench for axi_read_arbiter: grants, tie alternation,
// stalls, error trap and asynchronous reset.
module tb_axi_read_arbiter;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_valid;
    logic [31:0] d_addr;
    logic        d_ready;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        busy;
    logic        trap;
    logic [1:0]  trap_code;

    int n_cmp;
    int n_fail;

    axi_read_arbiter_if axi ();

    axi_read_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_valid   (d_valid),
        .d_addr    (d_addr),
        .d_ready   (d_ready),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .axi       (axi.master),
        .busy      (busy),
        .trap      (trap),
        .trap_code (trap_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        i_valid     = 1'b0;
        i_addr      = '0;
        d_valid     = 1'b0;
        d_addr      = '0;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = '0;
        #12;
        n_cmp++;
        if ({axi.arvalid, axi.rready, i_ready, d_ready, i_rvalid, d_rvalid, i_err, d_err, busy, trap, trap_code} !== 12'h000) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl: got %b want 000000000000",
                     {axi.arvalid, axi.rready, i_ready, d_ready, i_rvalid, d_rvalid, i_err, d_err, busy, trap, trap_code});
        end
        n_cmp++;
        if ({axi.araddress, axi.arprot, i_rdata, d_rdata} !== 99'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_data: got %h/%b/%h/%h want zeros", axi.araddress, axi.arprot, i_rdata, d_rdata);
        end
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || axi.arvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got busy=%b arvalid=%b want 0/0", busy, axi.arvalid);
        end
    endtask

    task automatic test_single_fetch();
        i_valid     = 1'b1;
        i_addr      = 32'h100;
        axi.arready = 1'b1;
        tick();
        n_cmp++;
        if ({axi.arvalid, i_ready, d_ready, busy} !== 4'b1101 || axi.araddress !== 32'h100 || axi.arprot !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL fetch_c1: got arv/ir/dr/busy=%b addr=%h prot=%b want 1101 100 101",
                     {axi.arvalid, i_ready, d_ready, busy}, axi.araddress, axi.arprot);
        end
        i_valid = 1'b0;
        tick();
        n_cmp++;
        if ({axi.arvalid, axi.rready, i_ready} !== 3'b010) begin
            n_fail++;
            $display("[TB] FAIL fetch_c2: got arv/rr/ir=%b want 010", {axi.arvalid, axi.rready, i_ready});
        end
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hDEADBEEF;
        axi.rresp  = 2'b00;
        tick();
        n_cmp++;
        if ({i_rvalid, i_err, d_rvalid, busy, axi.rready} !== 5'b10000 || i_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL fetch_c3: got irv/ie/drv/busy/rr=%b rdata=%h want 10000 deadbeef",
                     {i_rvalid, i_err, d_rvalid, busy, axi.rready}, i_rdata);
        end
        n_cmp++;
        if (d_rdata !== 32'h0 || d_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fetch_d_untouched: got d_rdata=%h d_err=%b want 0/0", d_rdata, d_err);
        end
        axi.rvalid = 1'b0;
        tick();
        n_cmp++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL fetch_hold: got irv=%b rdata=%h want 0 deadbeef", i_rvalid, i_rdata);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_tie();
        do_reset();
        i_valid = 1'b1;
        i_addr  = 32'h200;
        d_valid = 1'b1;
        d_addr  = 32'h300;
        tick();
        n_cmp++;
        if ({i_ready, d_ready} !== 2'b10 || axi.araddress !== 32'h200 || axi.arprot !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL tie1_grant: got ir/dr=%b addr=%h prot=%b want 10 200 101",
                     {i_ready, d_ready}, axi.araddress, axi.arprot);
        end
        i_valid = 1'b0;
        tick();
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h11111111;
        tick();
        n_cmp++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h11111111 || d_rvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL tie1_resp: got irv=%b rdata=%h drv=%b want 1 11111111 0", i_rvalid, i_rdata, d_rvalid);
        end
        axi.rvalid = 1'b0;
        i_valid    = 1'b1;
        i_addr     = 32'h204;
        tick();
        n_cmp++;
        if ({i_ready, d_ready} !== 2'b01 || axi.araddress !== 32'h300 || axi.arprot !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL tie2_grant: got ir/dr=%b addr=%h prot=%b want 01 300 000",
                     {i_ready, d_ready}, axi.araddress, axi.arprot);
        end
        d_valid = 1'b0;
        tick();
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h22222222;
        tick();
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h22222222 || i_rvalid !== 1'b0 || i_rdata !== 32'h11111111) begin
            n_fail++;
            $display("[TB] FAIL tie2_resp: got drv=%b drdata=%h irv=%b irdata=%h want 1 22222222 0 11111111",
                     d_rvalid, d_rdata, i_rvalid, i_rdata);
        end
        axi.rvalid = 1'b0;
        tick();
        n_cmp++;
        if (i_ready !== 1'b1 || axi.araddress !== 32'h204 || axi.arprot !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL tie_pending_fetch: got ir=%b addr=%h prot=%b want 1 204 101", i_ready, axi.araddress, axi.arprot);
        end
        i_valid = 1'b0;
        tick();
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h33333333;
        tick();
        n_cmp++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'h33333333 || d_rdata !== 32'h22222222) begin
            n_fail++;
            $display("[TB] FAIL tie_fetch_resp: got irv=%b irdata=%h drdata=%h want 1 33333333 22222222", i_rvalid, i_rdata, d_rdata);
        end
        axi.rvalid = 1'b0;
    endtask

    task automatic test_stalls();
        d_valid     = 1'b1;
        d_addr      = 32'h400;
        axi.arready = 1'b0;
        tick();
        d_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_cmp++;
            if (axi.arvalid !== 1'b1 || axi.araddress !== 32'h400 || axi.rready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_addr_c%0d: got arv=%b addr=%h rr=%b want 1 400 0", c, axi.arvalid, axi.araddress, axi.rready);
            end
            if (c == 4) axi.arready = 1'b1;
            tick();
        end
        axi.arready = 1'b0;
        axi.rresp   = 2'b01;
        for (int c = 5; c <= 7; c++) begin
            n_cmp++;
            if (axi.rready !== 1'b1 || axi.arvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL stall_data_c%0d: got rr=%b arv=%b drv=%b want 1 0 0", c, axi.rready, axi.arvalid, d_rvalid);
            end
            if (c == 7) begin
                axi.rvalid = 1'b1;
                axi.rdata  = 32'h44444444;
            end
            tick();
        end
        n_cmp++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h44444444 || d_err !== 1'b0 || trap !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stall_resp_c8: got drv=%b drdata=%h derr=%b trap=%b want 1 44444444 0 0", d_rvalid, d_rdata, d_err, trap);
        end
        axi.rvalid  = 1'b0;
        axi.rresp   = 2'b00;
        axi.arready = 1'b1;
    endtask

    task automatic test_error();
        d_valid = 1'b1;
        d_addr  = 32'h500;
        tick();
        d_valid = 1'b0;
        tick();
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h55555555;
        axi.rresp  = 2'b10;
        tick();
        n_cmp++;
        if ({d_rvalid, d_err, trap} !== 3'b111 || trap_code !== 2'b00 || d_rdata !== 32'h55555555) begin
            n_fail++;
            $display("[TB] FAIL err_resp: got drv/derr/trap=%b code=%b drdata=%h want 111 00 55555555",
                     {d_rvalid, d_err, trap}, trap_code, d_rdata);
        end
        axi.rvalid = 1'b0;
        axi.rresp  = 2'b00;
        i_valid    = 1'b1;
        i_addr     = 32'h600;
        tick();
        i_valid = 1'b0;
        tick();
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h66666666;
        tick();
        n_cmp++;
        if ({i_rvalid, i_err, trap, d_err} !== 4'b1011 || i_rdata !== 32'h66666666) begin
            n_fail++;
            $display("[TB] FAIL err_followup: got irv/ierr/trap/derr=%b irdata=%h want 1011 66666666",
                     {i_rvalid, i_err, trap, d_err}, i_rdata);
        end
        axi.rvalid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_data();
        i_valid = 1'b1;
        i_addr  = 32'h700;
        tick();
        i_valid = 1'b0;
        tick();
        n_cmp++;
        if (axi.rready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_pre_reset: got rready=%b want 1", axi.rready);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({axi.arvalid, axi.rready, i_ready, d_ready, i_rvalid, d_rvalid, i_err, d_err, busy, trap, trap_code} !== 12'h000
            || {axi.araddress, axi.arprot, i_rdata, d_rdata} !== 99'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_async_reset: got ctrl=%b addr=%h prot=%b ird=%h drd=%h want all zero",
                     {axi.arvalid, axi.rready, i_ready, d_ready, i_rvalid, d_rvalid, i_err, d_err, busy, trap, trap_code},
                     axi.araddress, axi.arprot, i_rdata, d_rdata);
        end
        tick();
        reset   = 1'b1;
        i_valid = 1'b1;
        i_addr  = 32'h800;
        d_valid = 1'b1;
        d_addr  = 32'h900;
        tick();
        n_cmp++;
        if ({i_ready, d_ready} !== 2'b10 || axi.araddress !== 32'h800 || axi.arprot !== 3'b101) begin
            n_fail++;
            $display("[TB] FAIL post_reset_tie: got ir/dr=%b addr=%h prot=%b want 10 800 101",
                     {i_ready, d_ready}, axi.araddress, axi.arprot);
        end
        i_valid = 1'b0;
        d_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single_fetch();
        test_tie();
        test_stalls();
        test_error();
        test_reset_mid_data();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
